// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   req_id_t     : requester identifier (0 or 1)
//   NREQ         : number of requesters
//   DEF_MEM_AW   : default memory address width
//   DEF_MEM_DW   : default memory data width
//   DEF_RD_DEPTH : default number of reads that may be in flight
package mem_arb_pkg;

    typedef logic req_id_t;

    localparam int NREQ         = 2;
    localparam int DEF_MEM_AW   = 16;
    localparam int DEF_MEM_DW   = 32;
    localparam int DEF_RD_DEPTH = 8;

endpackage

// File: rtl/tag_fifo.sv
// Read-tag FIFO. Remembers which requester issued each outstanding read so
// in-order memory returns can be steered back to the right requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : enqueue push_id this cycle
//   push_id    : requester id of the read being issued
//   pop        : dequeue the head this cycle
//   head       : requester id at the head of the queue
//   count      : number of entries held, 0..DEPTH
module tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_RD_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  req_id_t                    push_id,
    input  logic                       pop,
    output req_id_t                    head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    req_id_t         slots [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Guard against overfill / underflow even though the arbiter already
    // prevents both.
    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_id;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter with in-order read return routing.
//   clk, rst_n             : clock, asynchronous active-low reset
//   rN_req/write/addr/wdata: access request from requester N (N = 0, 1)
//   rN_gnt                 : request accepted this cycle (combinational)
//   rN_rdata_vld/rdata     : read return for requester N
//   mem_req/write/addr/wdata: registered command to memory
//   mem_rdata_vld/rdata    : in-order read return from memory
//   err_ovf                : sticky, read data arrived with nothing outstanding
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_AW   = DEF_MEM_AW,
    parameter int MEM_DW   = DEF_MEM_DW,
    parameter int RD_DEPTH = DEF_RD_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [MEM_AW-1:0] r0_addr,
    input  logic [MEM_DW-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rdata_vld,
    output logic [MEM_DW-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [MEM_AW-1:0] r1_addr,
    input  logic [MEM_DW-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rdata_vld,
    output logic [MEM_DW-1:0] r1_rdata,
    output logic              mem_req,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    input  logic              mem_rdata_vld,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic              err_ovf
);

    localparam int CW = $clog2(RD_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(RD_DEPTH);

    req_id_t           rr_last;
    req_id_t           tag_head;
    logic [CW-1:0]     tag_count;
    logic              tags_full;
    logic              ok0;
    logic              ok1;
    logic              any_gnt;
    logic              sel_write;
    logic [MEM_AW-1:0] sel_addr;
    logic [MEM_DW-1:0] sel_wdata;
    logic              tag_push;
    logic              tag_pop;

    // A full tag FIFO blocks reads even if a pop happens in the same cycle,
    // keeping the grant path independent of mem_rdata_vld.
    assign tags_full = (tag_count == FULL);
    assign ok0       = r0_req && (r0_write || !tags_full);
    assign ok1       = r1_req && (r1_write || !tags_full);

    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rst_n) begin
            if (ok0 && ok1) begin
                if (rr_last == 1'b1) r0_gnt = 1'b1;
                else                 r1_gnt = 1'b1;
            end else if (ok0) begin
                r0_gnt = 1'b1;
            end else if (ok1) begin
                r1_gnt = 1'b1;
            end
        end
    end

    assign any_gnt   = r0_gnt | r1_gnt;
    assign sel_write = r1_gnt ? r1_write : r0_write;
    assign sel_addr  = r1_gnt ? r1_addr  : r0_addr;
    assign sel_wdata = r1_gnt ? r1_wdata : r0_wdata;

    assign tag_push = any_gnt && !sel_write;
    assign tag_pop  = mem_rdata_vld && (tag_count != '0);

    tag_fifo #(
        .DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tag_push),
        .push_id (req_id_t'(r1_gnt)),
        .pop     (tag_pop),
        .head    (tag_head),
        .count   (tag_count)
    );

    assign r0_rdata_vld = rst_n && tag_pop && (tag_head == 1'b0);
    assign r1_rdata_vld = rst_n && tag_pop && (tag_head == 1'b1);
    assign r0_rdata     = mem_rdata;
    assign r1_rdata     = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rr_last   <= 1'b1;
            err_ovf   <= 1'b0;
        end else begin
            mem_req <= any_gnt;
            if (any_gnt) begin
                mem_write <= sel_write;
                mem_addr  <= sel_addr;
                rr_last   <= req_id_t'(r1_gnt);
                if (sel_write) mem_wdata <= sel_wdata;
            end else begin
                mem_write <= 1'b0;
            end
            if (mem_rdata_vld && (tag_count == '0)) err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_req, r0_write, r1_req, r1_write;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rdata_vld, r1_rdata_vld;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_req, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdata_vld;
    logic [DW-1:0] mem_rdata;
    logic          err_ovf;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_AW(AW), .MEM_DW(DW), .RD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rdata_vld(r0_rdata_vld), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rdata_vld(r1_rdata_vld), .r1_rdata(r1_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata), .err_ovf(err_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
        mem_rdata_vld = 1'b1; mem_rdata = '0;

        // reset values, outputs gated while in reset
        @(negedge clk); @(negedge clk); #1;
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_mem_write", 64'(mem_write), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_wdata", 64'(mem_wdata), 0);
        chk("rst_err_ovf", 64'(err_ovf), 0);
        chk("rst_r0_gnt", 64'(r0_gnt), 0);
        chk("rst_r0_rvld", 64'(r0_rdata_vld), 0);
        @(negedge clk);
        rst_n = 1'b1; r0_req = 1'b0; mem_rdata_vld = 1'b0;

        // single write from r0
        @(negedge clk);
        r0_req = 1'b1; r0_write = 1'b1; r0_addr = 16'h0010; r0_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_r0_gnt", 64'(r0_gnt), 1);
        chk("wr_r1_gnt", 64'(r1_gnt), 0);
        @(negedge clk);
        chk("wr_mem_req", 64'(mem_req), 1);
        chk("wr_mem_write", 64'(mem_write), 1);
        chk("wr_mem_addr", 64'(mem_addr), 64'h0010);
        chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        r0_req = 1'b0;
        @(negedge clk);
        chk("idle_mem_req", 64'(mem_req), 0);
        chk("idle_wdata_hold", 64'(mem_wdata), 64'hDEADBEEF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // both requesters reading, memory latency 2
        @(negedge clk);
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 16'h0100;
        r1_req = 1'b1; r1_write = 1'b0; r1_addr = 16'h0200;
        #1;
        chk("rr0_r0_gnt", 64'(r0_gnt), 1);
        chk("rr0_r1_gnt", 64'(r1_gnt), 0);
        @(negedge clk);
        chk("rr1_mem_req", 64'(mem_req), 1);
        chk("rr1_mem_write", 64'(mem_write), 0);
        chk("rr1_mem_addr", 64'(mem_addr), 64'h0100);
        r0_addr = 16'h0101;
        #1;
        chk("rr1_r1_gnt", 64'(r1_gnt), 1);
        chk("rr1_r0_gnt", 64'(r0_gnt), 0);
        @(negedge clk);
        chk("rr2_mem_addr", 64'(mem_addr), 64'h0200);
        r1_addr = 16'h0201;
        #1;
        chk("rr2_r0_gnt", 64'(r0_gnt), 1);
        @(negedge clk);
        chk("rr3_mem_addr", 64'(mem_addr), 64'h0101);
        r0_addr = 16'h0102;
        mem_rdata_vld = 1'b1; mem_rdata = 32'hA000_0100;
        #1;
        chk("rr3_r1_gnt", 64'(r1_gnt), 1);
        chk("rr3_r0_rvld", 64'(r0_rdata_vld), 1);
        chk("rr3_r1_rvld", 64'(r1_rdata_vld), 0);
        chk("rr3_r0_rdata", 64'(r0_rdata), 64'hA000_0100);
        chk("rr3_r1_rdata", 64'(r1_rdata), 64'hA000_0100);
        @(negedge clk);
        chk("rr4_mem_addr", 64'(mem_addr), 64'h0201);
        r0_req = 1'b0; r1_req = 1'b0;
        mem_rdata = 32'hA000_0200;
        #1;
        chk("rr4_r1_rvld", 64'(r1_rdata_vld), 1);
        chk("rr4_r0_rvld", 64'(r0_rdata_vld), 0);
        chk("rr4_r1_rdata", 64'(r1_rdata), 64'hA000_0200);
        @(negedge clk);
        mem_rdata = 32'hA000_0101;
        #1;
        chk("rr5_r0_rvld", 64'(r0_rdata_vld), 1);
        chk("rr5_r1_rvld", 64'(r1_rdata_vld), 0);
        @(negedge clk);
        mem_rdata = 32'hA000_0201;
        #1;
        chk("rr6_r1_rvld", 64'(r1_rdata_vld), 1);
        chk("rr6_r0_rvld", 64'(r0_rdata_vld), 0);

        // return with nothing outstanding
        @(negedge clk);
        chk("ovf_before", 64'(err_ovf), 0);
        mem_rdata = 32'h0000_0BAD;
        #1;
        chk("ovf_r0_rvld", 64'(r0_rdata_vld), 0);
        chk("ovf_r1_rvld", 64'(r1_rdata_vld), 0);
        @(negedge clk);
        mem_rdata_vld = 1'b0;
        chk("ovf_set", 64'(err_ovf), 1);
        @(negedge clk);
        @(negedge clk);
        chk("ovf_sticky", 64'(err_ovf), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("ovf_cleared", 64'(err_ovf), 0);

        // fill the tag FIFO: 7 reads from r0, 1 from r1
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            r0_req = 1'b1; r0_write = 1'b0; r0_addr = 16'h0300 + 16'(i);
            #1;
            chk("fill_r0_gnt", 64'(r0_gnt), 1);
        end
        @(negedge clk);
        r0_req = 1'b0;
        r1_req = 1'b1; r1_write = 1'b0; r1_addr = 16'h0307;
        #1;
        chk("fill_r1_gnt", 64'(r1_gnt), 1);
        // full: preferred r0 read blocked, r1 write granted
        @(negedge clk);
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 16'h0308;
        r1_req = 1'b1; r1_write = 1'b1; r1_addr = 16'h0400; r1_wdata = 32'h1234_5678;
        #1;
        chk("full_r0_gnt", 64'(r0_gnt), 0);
        chk("full_r1_wr_gnt", 64'(r1_gnt), 1);
        @(negedge clk);
        chk("full_mem_write", 64'(mem_write), 1);
        chk("full_mem_addr", 64'(mem_addr), 64'h0400);
        chk("full_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
        r1_req = 1'b0;
        #1;
        chk("full_r0_still_blk", 64'(r0_gnt), 0);
        // pop in same cycle as blocked read
        @(negedge clk);
        mem_rdata_vld = 1'b1;
        #1;
        chk("pop_r0_gnt", 64'(r0_gnt), 0);
        chk("pop_r0_rvld", 64'(r0_rdata_vld), 1);
        @(negedge clk);
        mem_rdata_vld = 1'b0;
        #1;
        chk("after_pop_r0_gnt", 64'(r0_gnt), 1);
        @(negedge clk);
        chk("refill_mem_req", 64'(mem_req), 1);
        chk("refill_mem_write", 64'(mem_write), 0);
        chk("refill_mem_addr", 64'(mem_addr), 64'h0308);
        r0_addr = 16'h0309;
        #1;
        chk("refull_r0_gnt", 64'(r0_gnt), 0);
        r0_req = 1'b0;
        // drain five r0 tags, leaving r0, r1, r0 outstanding
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_rdata_vld = 1'b1;
            #1;
            chk("drain_r0_rvld", 64'(r0_rdata_vld), 1);
        end

        // reset with 3 reads outstanding
        @(negedge clk);
        rst_n = 1'b0;
        r0_req = 1'b1; r0_write = 1'b0;
        #1;
        chk("mid_rst_mem_req", 64'(mem_req), 0);
        chk("mid_rst_mem_addr", 64'(mem_addr), 0);
        chk("mid_rst_mem_wdata", 64'(mem_wdata), 0);
        chk("mid_rst_r0_gnt", 64'(r0_gnt), 0);
        chk("mid_rst_r0_rvld", 64'(r0_rdata_vld), 0);
        chk("mid_rst_r1_rvld", 64'(r1_rdata_vld), 0);
        chk("mid_rst_err_ovf", 64'(err_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1; r0_req = 1'b0;
        #1;
        chk("late_r0_rvld", 64'(r0_rdata_vld), 0);
        chk("late_r1_rvld", 64'(r1_rdata_vld), 0);
        @(negedge clk);
        mem_rdata_vld = 1'b0;
        chk("late_err_ovf", 64'(err_ovf), 1);
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 16'h0600;
        r1_req = 1'b1; r1_write = 1'b0; r1_addr = 16'h0700;
        #1;
        chk("post_r0_first", 64'(r0_gnt), 1);
        chk("post_r1_wait", 64'(r1_gnt), 0);
        @(negedge clk);
        r0_req = 1'b0;
        #1;
        chk("post_r1_gnt", 64'(r1_gnt), 1);
        @(negedge clk);
        r1_req = 1'b0;
        mem_rdata_vld = 1'b1; mem_rdata = 32'hB000_0600;
        #1;
        chk("post_ret0_r0", 64'(r0_rdata_vld), 1);
        chk("post_ret0_r1", 64'(r1_rdata_vld), 0);
        @(negedge clk);
        mem_rdata = 32'hB000_0700;
        #1;
        chk("post_ret1_r1", 64'(r1_rdata_vld), 1);
        chk("post_ret1_r0", 64'(r0_rdata_vld), 0);
        chk("post_ret1_data", 64'(r1_rdata), 64'hB000_0700);
        @(negedge clk);
        mem_rdata_vld = 1'b0;
        chk("post_ovf_sticky", 64'(err_ovf), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_AW, default 16, memory address width.
REQ-002 Parameter MEM_DW, default 32, memory data width.
REQ-003 Parameter RD_DEPTH, default 8, max outstanding reads (power of 2, >=2).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rN_req  in  1  (N=0,1) requester N wants a memory access this cycle.
REQ-007 rN_write  in  1  1=write, 0=read.
REQ-008 rN_addr  in  MEM_AW  access address.
REQ-009 rN_wdata  in  MEM_DW  write data.
REQ-010 rN_gnt  out  1  request accepted this cycle.
REQ-011 rN_rdata_vld  out  1  read data for requester N valid.
REQ-012 rN_rdata  out  MEM_DW  read data.
REQ-013 mem_req, mem_write  out  1  memory command strobe / type.
REQ-014 mem_addr  out  MEM_AW; mem_wdata  out  MEM_DW  command fields.
REQ-015 mem_rdata_vld  in  1; mem_rdata  in  MEM_DW  in-order read return, any latency >=1.
REQ-016 err_ovf  out  1  sticky: read data returned with no outstanding read.

Function
REQ-017 Grant combinational: rN_gnt depends on current rN_req, rr_last, tag count only.
REQ-018 At most one of r0_gnt/r1_gnt high per cycle; never gnt without req.
REQ-019 Round-robin: both requesting -> grant requester != rr_last; rr_last updates to granted id on each grant.
REQ-020 Single requester -> granted immediately unless blocked (REQ-021).
REQ-021 Read request blocked (gnt=0) while tag count == RD_DEPTH, regardless of same-cycle pop; writes never blocked.
REQ-022 If preferred requester is a blocked read and other requests a write, the write is granted.
REQ-023 Granted command registered: mem_req/mem_write/mem_addr/mem_wdata show it the next cycle (1-cycle latency); mem_req=0 in cycles after no grant.
REQ-024 mem_wdata holds previous value on reads and idle cycles.
REQ-025 Each granted read pushes its requester id into tag FIFO in grant cycle.
REQ-026 mem_rdata_vld pops FIFO head; rN_rdata_vld = mem_rdata_vld & head==N, same cycle (0-cycle latency).
REQ-027 r0_rdata = r1_rdata = mem_rdata (broadcast, unregistered).
REQ-028 Push and pop in same cycle -> count unchanged, order preserved.
REQ-029 mem_rdata_vld with count==0 -> no rN_rdata_vld, no pop, err_ovf set until reset.
REQ-030 Tag count range 0..RD_DEPTH; read pointers wrap modulo RD_DEPTH.

Reset
REQ-031 rst_n low: mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, rr_last=1 (requester 0 wins first tie), tag FIFO empty, err_ovf=0.
REQ-032 Reset mid-operation discards outstanding reads; late returns after reset follow REQ-029.
REQ-033 rN_gnt=0 and rN_rdata_vld=0 while rst_n low.

Structure
REQ-034 Package mem_arb_pkg holds requester-id type (1 bit), NREQ=2 constant, default width constants.
REQ-035 Tag FIFO is sub-module tag_fifo (sync, width 1, depth RD_DEPTH, push/pop/count/head, simultaneous push+pop).
REQ-036 Grant logic and command register remain in mem_arbiter; total RTL 120-400 lines.

Verification
REQ-037 Both request reads continuously, mem latency 2 -> grants alternate 0,1,0,1 from reset; each rN_rdata_vld matches own addresses in order.
REQ-038 r0 write addr 0x0010 data 0xDEADBEEF alone -> r0_gnt same cycle; next cycle mem_req=1, mem_write=1, mem_addr=0x0010, mem_wdata=0xDEADBEEF.
REQ-039 8 reads issued, memory withholds data -> 9th read gnt=0; r1 write same cycle granted; after one mem_rdata_vld, read granted next cycle.
REQ-040 Count=8 with pop in same cycle as r0 read request -> r0_gnt=0 that cycle, count becomes 7, granted next cycle.
REQ-041 mem_rdata_vld pulse with empty FIFO -> no rN_rdata_vld, err_ovf=1 and stays 1 until rst_n low.
REQ-042 Assert rst_n low with 3 reads outstanding -> all outputs reset values; post-reset return sets err_ovf; new reads then route correctly.
